// File: rtl/rr_arb_mux_pkg.sv
// rr_mux_pkg: shared types, defaults and index helpers for rr_arb_mux
package rr_mux_pkg;
  typedef enum logic {EMPTY, FULL} ostate_e;
  localparam int DEF_N = 4;
  localparam int DEF_W = 8;
  localparam int DEF_RST_PTR = DEF_N - 1;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int next_idx(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: channel/consumer bundle; slave is the mux side, master the environment side
interface rr_arb_mux_if import rr_mux_pkg::*; #(parameter int N = DEF_N, parameter int W = DEF_W);
  localparam int SELW = idx_w(N);
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_last;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic [SELW-1:0] out_sel;
  logic out_last;
  logic out_valid;
  logic out_ready;
  modport slave(input in_data, in_valid, in_last, out_ready, output in_ready, out_data, out_sel, out_last, out_valid);
  modport master(output in_data, in_valid, in_last, out_ready, input in_ready, out_data, out_sel, out_last, out_valid);
endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// rr_arbiter: combinational round-robin grant, scanning from ptr+1 modulo N; a held lock overrides the scan
module rr_arbiter import rr_mux_pkg::*; #(parameter int N = DEF_N) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  input  logic                  lock,
  input  logic [idx_w(N)-1:0]   lock_idx,
  output logic [N-1:0]          grant_oh,
  output logic [idx_w(N)-1:0]   grant_idx
);
  localparam int SELW = idx_w(N);
  always_comb begin
    logic [SELW-1:0] idx;
    logic found;
    grant_oh = '0;
    grant_idx = lock_idx;
    found = lock;
    idx = ptr;
    if (lock) grant_oh[lock_idx] = req[lock_idx];
    for (int k = 0; k < N; k++) begin
      idx = SELW'(next_idx(int'(idx), N));
      if (!found && req[idx]) begin
        grant_oh[idx] = 1'b1;
        grant_idx = idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbitrated mux with a registered, pass-through-ready output stage.
// Define RR_ARB_LOCK_EN to keep the grant on one channel for a whole packet (until in_last).
module rr_arb_mux import rr_mux_pkg::*; #(parameter int N = DEF_N, parameter int W = DEF_W) (
  input logic          clk,
  input logic          rst,
  rr_arb_mux_if.slave  bus
);
  localparam int SELW = idx_w(N);
  ostate_e state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d, ptr_q, ptr_d, grant_idx, lock_idx;
  logic last_q, last_d, lock, load, xfer, beat_last, ptr_upd;
  logic [N-1:0] grant_oh;
  logic [W-1:0] ch_data [N];
  rr_arbiter #(.N(N)) u_arb (
    .req(bus.in_valid), .ptr(ptr_q), .lock(lock), .lock_idx(lock_idx),
    .grant_oh(grant_oh), .grant_idx(grant_idx)
  );
  assign load = state_q == EMPTY || bus.out_ready;
  // gated by rst so nothing is accepted while the output stage is held in reset
  assign bus.in_ready = (load && !rst) ? grant_oh : '0;
  assign xfer = |bus.in_ready;
`ifdef RR_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic [SELW-1:0] lock_idx_q, lock_idx_d;
  assign beat_last = bus.in_last[grant_idx];
  assign lock = lock_q;
  assign lock_idx = lock_idx_q;
  assign ptr_upd = xfer && beat_last;
  always_comb begin
    lock_d = xfer ? !beat_last : lock_q;
    lock_idx_d = xfer ? grant_idx : lock_idx_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^bus.in_last;
  assign beat_last = 1'b0;
  assign lock = 1'b0;
  assign lock_idx = '0;
  assign ptr_upd = xfer;
`endif
  always_comb begin
    for (int i = 0; i < N; i++) ch_data[i] = bus.in_data[i*W +: W];
  end
  always_comb begin
    state_d = load ? (xfer ? FULL : EMPTY) : state_q;
    data_d = xfer ? ch_data[grant_idx] : data_q;
    sel_d = xfer ? grant_idx : sel_q;
    last_d = xfer ? beat_last : last_q;
    ptr_d = ptr_upd ? grant_idx : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q <= '0;
      sel_q <= '0;
      last_q <= 1'b0;
      ptr_q <= SELW'(N - 1);
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      sel_q <= sel_d;
      last_q <= last_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.out_valid = state_q == FULL;
  assign bus.out_data = data_q;
  assign bus.out_sel = sel_q;
  assign bus.out_last = last_q;
endmodule
